memory_store_merger: RTL

- Store-side counterpart of the load sign-extension path in the MEM stage.
- Takes a store request (address, register data, size) from the pipeline and drives a word-only data memory.
- Word stores are written directly.
- Byte and halfword stores use read-modify-write: the unit reads the containing word, merges the lane, and writes it back.
- Asserts busy to stall the pipeline while a store is in flight.

---
 rtl/memory_pkg.sv | 35 +++
 rtl/memory_store_merger_if.sv | 29 ++
 rtl/store_lane_merge.sv | 32 +++
 rtl/memory_store_merger.sv | 88 ++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared size encodings, store FSM states and lane offsets for the MEM stage
package memory_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_BYTE = 2'd2,
        SIZE_BAD  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT
    } state_e;

    // Big-endian lane offsets: offset 0 is the most significant lane.
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;
    localparam logic [1:0] LANE_H0 = 2'd0;
    localparam logic [1:0] LANE_H1 = 2'd2;

    function automatic logic store_aligned(input size_e size, input logic [1:0] off);
        case (size)
            SIZE_WORD: store_aligned = (off == 2'd0);
            SIZE_HALF: store_aligned = !off[0];
            SIZE_BYTE: store_aligned = 1'b1;
            default:   store_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_store_merger_if.sv
// rtl/memory_store_merger_if.sv - pipeline store request and word-memory port bundle
interface memory_store_merger_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              busy;
    logic              done;
    logic              misaligned;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rd_data;
    logic              mem_rd_valid;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rd_data, mem_rd_valid,
        input  req_ready, busy, done, misaligned, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rd_data, mem_rd_valid,
        output req_ready, busy, done, misaligned, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - insert a byte or halfword into a big-endian word, other lanes kept
module store_lane_merge
    import memory_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  size_e       size,
    input  logic [1:0]  offset,
    output logic [31:0] merged_word
);

    always_comb begin
        merged_word = new_data;
        case (size)
            SIZE_HALF: begin
                if (offset == LANE_H0) merged_word = {new_data[15:0], old_word[15:0]};
                else                   merged_word = {old_word[31:16], new_data[15:0]};
            end
            SIZE_BYTE: begin
                case (offset)
                    LANE_B0: merged_word = {new_data[7:0], old_word[23:0]};
                    LANE_B1: merged_word = {old_word[31:24], new_data[7:0], old_word[15:0]};
                    LANE_B2: merged_word = {old_word[31:16], new_data[7:0], old_word[7:0]};
                    LANE_B3: merged_word = {old_word[31:8], new_data[7:0]};
                    default: merged_word = new_data;
                endcase
            end
            default: merged_word = new_data;
        endcase
    end

endmodule

// File: rtl/memory_store_merger.sv
// rtl/memory_store_merger.sv - store unit: direct word writes, read-modify-write for sub-word stores
module memory_store_merger
    import memory_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    memory_store_merger_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    size_e             size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              misaligned_q, misaligned_d;
    logic [DATA_W-1:0] merged;
    size_e             req_size;

    assign req_size = size_e'(bus.req_size);

    // wdata_q doubles as the latched store data until the merge overwrites it.
    store_lane_merge u_merge (
        .old_word    (bus.mem_rd_data),
        .new_data    (wdata_q),
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .merged_word (merged)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        misaligned_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (store_aligned(req_size, bus.req_addr[1:0])) begin
                        addr_d  = bus.req_addr;
                        size_d  = req_size;
                        wdata_d = bus.req_data;
                        state_d = (req_size == SIZE_WORD) ? ST_WRITE : ST_READ;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.mem_rd_valid) begin
                    wdata_d = merged;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= SIZE_WORD;
            wdata_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.done        = (state_q == ST_WRITE);
    assign bus.mem_wr_en   = (state_q == ST_WRITE);
    assign bus.mem_rd_en   = (state_q == ST_READ);
    assign bus.misaligned  = misaligned_q;
    assign bus.mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wr_data = wdata_q;

endmodule
